dff_exerciser: RTL
==================

# dff_exerciser

Self-checking exerciser for the team's negative-edge D flip-flop with asynchronous clear, i.e. the driving and checking end of that flip-flop's d/clr/q/qbar interface. It generates pseudo-random data with an 8-bit LFSR and inserts periodic clear pulses. It samples the flip-flop outputs one cycle after each stimulus and compares them against an internal expected model. It sits beside the flip-flop on the shared clock and reports vector count, error count and pass/fail.

## Interface
- NUM_VECTORS, 64: data vectors per run (1..255); clear cycles are not counted.
- CLR_PERIOD, 8: a clear cycle is inserted after every CLR_PERIOD-th data vector while vectors remain (≥1).
- SEED, 8'hA5: LFSR load value; 8'h00 is replaced by 8'h01.
- clk  in  1  single clock; exerciser logic on posedge, flip-flop under test on negedge of the same clk.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE, ignored while busy.
- dut_d  out  1  data to flip-flop.
- dut_clr  out  1  active-high async clear to flip-flop.
- dut_q  in  1  flip-flop q.
- dut_qbar  in  1  flip-flop qbar.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid when done: err_count==0.
- vec_count  out  8  data vectors driven this run.
- err_count  out  8  mismatches this run, saturating at 8'hFF.

## Operation
- Reset (clr_n low, asynchronous): state IDLE; dut_d=0, dut_clr=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, LFSR=SEED, check_pending=0.
- LFSR: shift left, feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] into bit 0; dut_d takes lfsr[7] before each shift.
- States:
  - IDLE: on start, load LFSR, clear counters and done/pass, set busy, go to RUN.
  - RUN: each cycle drive dut_d=lfsr[7], advance the LFSR, increment vec_count, set exp_q=dut_d, and set check_pending. After driving vector k:
    - if k==NUM_VECTORS, go to FINAL;
    - else if k%CLR_PERIOD==0, go to CLEAR.
  - CLEAR: one cycle with dut_clr=1 and dut_d=1, so clear must dominate data; exp_q=0; check_pending=1.
  - FINAL: dut_d=0, dut_clr=0; perform the last check; go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0); start goes to RUN with a fresh load.
- Check: on every posedge with check_pending=1, a mismatch occurs if dut_q!=exp_q or dut_qbar!=~exp_q. A mismatch increments err_count, saturating. There is at most one increment per check, even if both outputs are wrong.
- No check happens before the first drive of a run, so the flip-flop's unknown power-up state is never compared.
- Simultaneous start and clr_n low: reset wins.
- Reset mid-run: abandons the run immediately, with all outputs at reset values.

## Timing
- Stimulus launched at posedge N is captured by the flip-flop at the negedge inside cycle N and checked at posedge N+1. Latency to check is 1 cycle.
- dut_clr is high for exactly one full cycle. The flip-flop's q must be 0 by posedge N+1 without waiting for a negedge.
- dut_clr deasserts on the same posedge that the next data vector launches; that vector is captured at the following negedge.
- Busy length = NUM_VECTORS + clears + 1 cycles, where clears = ceil(NUM_VECTORS/CLR_PERIOD) − 1. done rises on the posedge after FINAL.
- vec_count and err_count update on posedge only and are stable for a full cycle.

## Structure
- Package dff_ex_pkg:
  - state enum {IDLE, RUN, CLEAR, FINAL, DONE};
  - LFSR tap constant 8'hB8 (bits 7,5,4,3);
  - default seed 8'hA5.
- Sub-module lfsr8:
  - ports: clk, clr_n, load, seed, advance, out_bit;
  - seed-zero substitution is done inside it.
- Top: FSM, vector/error counters, expected-value register, comparator.

## Test plan
- Correct flip-flop, NUM_VECTORS=16, CLR_PERIOD=8, SEED=8'hA5: start → busy for 18 cycles; first dut_d=1; done=1, pass=1, err_count=0, vec_count=16.
- Flip-flop that ignores clear, NUM_VECTORS=16, CLR_PERIOD=4: 3 clear cycles → err_count=3, pass=0.
- q stuck at 0, NUM_VECTORS=16, SEED=8'hA5: err_count equals the number of 1s driven on dut_d (bench counts); clear checks raise no error.
- clr_n pulsed low at cycle 5 of a run: all outputs zero the same cycle; subsequent start reruns the full sequence with identical dut_d pattern.
- start held high through a run and start pulsed while busy: no restart until DONE. SEED=8'h00 run matches SEED=8'h01 run bit-for-bit.
- qbar stuck at 1 only, NUM_VECTORS=8, CLR_PERIOD=8: err_count = number of 1s driven, single increment per vector; err_count saturates at 8'hFF when NUM_VECTORS=255 with dut_q inverted.

Source files
------------

// File: rtl/dff_ex_pkg.sv
// Shared types and constants for the negative-edge DFF exerciser.
package dff_ex_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      CLEAR,
      FINAL,
      DONE
   } state_t;

   localparam logic [7:0] LFSR_TAPS    = 8'hB8;
   localparam logic [7:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/dff_exerciser_lfsr8.sv
// 8-bit Fibonacci LFSR (left shift, taps 7/5/4/3); an all-zero seed becomes 8'h01.
module lfsr8
   import dff_ex_pkg::*;
(
   input  logic       clk,
   input  logic       clr_n,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic       out_bit
);

   logic [7:0] r_lfsr;
   logic [7:0] w_seed;

   // All-zero is a lock-up state for this feedback.
   assign w_seed  = (seed == 8'h00) ? 8'h01 : seed;
   assign out_bit = r_lfsr[7];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_lfsr <= w_seed;
      end else if (load) begin
         r_lfsr <= w_seed;
      end else if (advance) begin
         r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/dff_exerciser.sv
// Drives pseudo-random data and periodic clears into a negedge DFF and checks q/qbar one cycle later.
module dff_exerciser
   import dff_ex_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 64,
   parameter int unsigned CLR_PERIOD  = 8,
   parameter logic [7:0]  SEED        = DEFAULT_SEED
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       start,
   output logic       dut_d,
   output logic       dut_clr,
   input  logic       dut_q,
   input  logic       dut_qbar,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] vec_count,
   output logic [7:0] err_count
);

   state_t     r_state, w_state_nxt;
   logic       r_d, r_clr, r_busy, r_done, r_pass, r_exp, r_pend;
   logic [7:0] r_vec, r_err, r_per;
   logic       w_d_nxt, w_clr_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt, w_exp_nxt, w_pend_nxt;
   logic [7:0] w_vec_nxt, w_err_nxt, w_per_nxt, w_err_upd;
   logic       w_load, w_adv, w_lfsr_bit, w_mismatch, w_per_hit, w_last_vec;

   lfsr8 u_lfsr (
      .clk     (clk),
      .clr_n   (clr_n),
      .load    (w_load),
      .seed    (SEED),
      .advance (w_adv),
      .out_bit (w_lfsr_bit)
   );

   // One check per pending stimulus; both outputs wrong still counts once.
   assign w_mismatch = r_pend && ((dut_q != r_exp) || (dut_qbar != ~r_exp));
   assign w_err_upd  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
   assign w_per_hit  = (r_per == 8'(CLR_PERIOD - 1));
   assign w_last_vec = ((r_vec + 8'd1) == 8'(NUM_VECTORS));

   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_clr_nxt   = r_clr;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_pass_nxt  = r_pass;
      w_exp_nxt   = r_exp;
      w_pend_nxt  = r_pend;
      w_vec_nxt   = r_vec;
      w_err_nxt   = w_err_upd;
      w_per_nxt   = r_per;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
               w_vec_nxt   = '0;
               w_err_nxt   = '0;
               w_per_nxt   = '0;
               w_done_nxt  = 1'b0;
               w_pass_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
               w_pend_nxt  = 1'b0;
            end
         end
         RUN: begin
            w_d_nxt    = w_lfsr_bit;
            w_clr_nxt  = 1'b0;
            w_adv      = 1'b1;
            w_vec_nxt  = r_vec + 8'd1;
            w_exp_nxt  = w_lfsr_bit;
            w_pend_nxt = 1'b1;
            w_per_nxt  = w_per_hit ? 8'd0 : r_per + 8'd1;
            if (w_last_vec) begin
               w_state_nxt = FINAL;
            end else if (w_per_hit) begin
               w_state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            // Data held high so the clear has to win over it.
            w_clr_nxt   = 1'b1;
            w_d_nxt     = 1'b1;
            w_exp_nxt   = 1'b0;
            w_pend_nxt  = 1'b1;
            w_state_nxt = RUN;
         end
         FINAL: begin
            w_d_nxt     = 1'b0;
            w_clr_nxt   = 1'b0;
            w_pend_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_upd == 8'd0);
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= IDLE;
         r_d     <= 1'b0;
         r_clr   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_exp   <= 1'b0;
         r_pend  <= 1'b0;
         r_vec   <= '0;
         r_err   <= '0;
         r_per   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_d     <= w_d_nxt;
         r_clr   <= w_clr_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_exp   <= w_exp_nxt;
         r_pend  <= w_pend_nxt;
         r_vec   <= w_vec_nxt;
         r_err   <= w_err_nxt;
         r_per   <= w_per_nxt;
      end
   end

   assign dut_d     = r_d;
   assign dut_clr   = r_clr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign vec_count = r_vec;
   assign err_count = r_err;

endmodule
